cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/seq_wait_timer.sv | 35 +++
 rtl/cpu_sequencer.sv | 138 +++++++++++++
 tb/tb_cpu_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes and PC source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpTrap = 4'b1111;

  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  function automatic logic is_alu_op(logic [3:0] op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpNot);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the rest of the CPU.
interface cpu_sequencer_if;
  logic        start_in;
  logic [3:0]  opcode_in;
  logic        mem_ready_in;
  logic        branch_taken_in;
  // Loads the instruction counter directly (bring-up and wrap testing).
  logic        cnt_preload_in;
  logic [15:0] cnt_preload_val_in;

  logic [2:0]  state_out;
  logic        mem_rd_out;
  logic        mem_wr_out;
  logic        ir_load_out;
  logic        pc_inc_out;
  logic [1:0]  pc_ctl_out;
  logic        we_reg_out;
  logic        br_out;
  logic        halt_out;
  logic        err_out;
  logic [15:0] instr_count_out;

  modport slave (
    input  start_in, opcode_in, mem_ready_in, branch_taken_in, cnt_preload_in,
           cnt_preload_val_in,
    output state_out, mem_rd_out, mem_wr_out, ir_load_out, pc_inc_out, pc_ctl_out,
           we_reg_out, br_out, halt_out, err_out, instr_count_out
  );

  modport master (
    output start_in, opcode_in, mem_ready_in, branch_taken_in, cnt_preload_in,
           cnt_preload_val_in,
    input  state_out, mem_rd_out, mem_wr_out, ir_load_out, pc_inc_out, pc_ctl_out,
           we_reg_out, br_out, halt_out, err_out, instr_count_out
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Counts consecutive memory wait cycles; timeout_o flags that the limit has been reached.
module seq_wait_timer #(
  parameter int unsigned MaxCount = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic cnt_en_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (MaxCount < 1) ? 1 : $clog2(MaxCount + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_o = (cnt_q == CntW'(MaxCount));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && !timeout_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic             clka,
  input logic             reset_in,
  cpu_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic       mem_rd, mem_wr, ir_load, pc_inc, we_reg, br;
  logic [1:0] pc_ctl;
  logic       timeout, wait_clear, wait_en;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    err_d    = err_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    we_reg   = 1'b0;
    br       = 1'b0;
    pc_ctl   = PcNext;
    case (state_q)
      StIdle: if (bus.start_in) state_d = StFetch;
      StFetch: begin
        mem_rd = 1'b1;
        if (bus.mem_ready_in) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StDecode: begin
        opcode_d = bus.opcode_in;
        state_d  = StExec;
      end
      StExec: begin
        if (is_alu_op(opcode_q)) begin
          state_d = StWb;
        end else if (opcode_q == OpBr) begin
          br      = 1'b1;
          pc_ctl  = {1'b0, bus.branch_taken_in};
          state_d = StFetch;
        end else if (opcode_q == OpJmp) begin
          pc_ctl  = PcJump;
          state_d = StFetch;
        end else if (opcode_q == OpLd || opcode_q == OpSt) begin
          state_d = StMem;
        end else begin
          // TRAP halts cleanly; anything unrecognised halts with an error.
          state_d = StHalt;
          err_d   = (opcode_q != OpTrap);
        end
      end
      StMem: begin
        mem_rd = (opcode_q == OpLd);
        mem_wr = (opcode_q == OpSt);
        if (bus.mem_ready_in) begin
          state_d = (opcode_q == OpLd) ? StWb : StFetch;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StWb: begin
        we_reg  = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: begin
        state_d = StHalt;
        err_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_preload_in) begin
      cnt_d = bus.cnt_preload_val_in;
    end else if (ir_load) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Restart the wait count on every entry into a memory-access state, including MEM -> FETCH.
  assign wait_clear = (state_d != state_q) && (state_d == StFetch || state_d == StMem);
  assign wait_en    = (state_q == StFetch || state_q == StMem) && !bus.mem_ready_in;

  seq_wait_timer #(
    .MaxCount (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clka),
    .rst_i     (reset_in),
    .clear_i   (wait_clear),
    .cnt_en_i  (wait_en),
    .timeout_o (timeout)
  );

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= StIdle;
      opcode_q <= 4'd0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.state_out       = state_q;
  assign bus.mem_rd_out      = mem_rd;
  assign bus.mem_wr_out      = mem_wr;
  assign bus.ir_load_out     = ir_load;
  assign bus.pc_inc_out      = pc_inc;
  assign bus.pc_ctl_out      = pc_ctl;
  assign bus.we_reg_out      = we_reg;
  assign bus.br_out          = br;
  assign bus.halt_out        = (state_q == StHalt);
  assign bus.err_out         = err_q;
  assign bus.instr_count_out = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-scenario tasks with hand-computed expectations.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clka = 1'b0;
  logic        reset_in;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt;

  cpu_sequencer_if bus();

  cpu_sequencer #(
    .MEM_WAIT_MAX (15)
  ) dut (
    .clka     (clka),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clka = ~clka;

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  // {mem_rd, mem_wr, ir_load, pc_inc, we_reg, br}
  function automatic logic [5:0] strobes();
    return {bus.mem_rd_out, bus.mem_wr_out, bus.ir_load_out, bus.pc_inc_out,
            bus.we_reg_out, bus.br_out};
  endfunction

  task automatic do_reset;
    reset_in = 1'b1;
    #2;
    step;
    reset_in = 1'b0;
    exp_cnt  = 16'd0;
  endtask

  task automatic test_reset;
    bus.start_in = 1'b0; bus.opcode_in = 4'd0; bus.mem_ready_in = 1'b1;
    bus.branch_taken_in = 1'b0; bus.cnt_preload_in = 1'b0; bus.cnt_preload_val_in = 16'd0;
    reset_in = 1'b1;
    #3;
    total++; if (bus.state_out !== 3'd0) begin bad++;
      $display("FAIL reset_state: got %0d want 0", bus.state_out); end
    total++; if (strobes() !== 6'd0) begin bad++;
      $display("FAIL reset_strobes: got %b want 000000", strobes()); end
    total++; if ({bus.halt_out, bus.err_out, bus.pc_ctl_out} !== 4'd0) begin bad++;
      $display("FAIL reset_status: got %b want 0000", {bus.halt_out, bus.err_out, bus.pc_ctl_out}); end
    step; step;
    total++; if (bus.instr_count_out !== 16'd0) begin bad++;
      $display("FAIL reset_count: got %0h want 0", bus.instr_count_out); end
    reset_in = 1'b0;
    exp_cnt  = 16'd0;
  endtask

  task automatic test_add;
    logic [2:0] exp_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    int we_n = 0;
    bus.opcode_in = OpAdd; bus.mem_ready_in = 1'b1; bus.start_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      if (i == 0) begin
        bus.start_in = 1'b0;
        total++; if ({bus.ir_load_out, bus.pc_inc_out} !== 2'b11) begin bad++;
          $display("FAIL add_fetch_strobes: got %b want 11", {bus.ir_load_out, bus.pc_inc_out}); end
      end
      total++; if (bus.state_out !== exp_seq[i]) begin bad++;
        $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state_out, exp_seq[i]); end
      if (bus.we_reg_out) we_n++;
    end
    exp_cnt = 16'd1;
    total++; if (we_n != 1) begin bad++;
      $display("FAIL add_we_pulses: got %0d want 1", we_n); end
    total++; if (bus.instr_count_out !== exp_cnt) begin bad++;
      $display("FAIL add_count: got %0h want %0h", bus.instr_count_out, exp_cnt); end
  endtask

  task automatic test_branch(input logic taken);
    bus.opcode_in = OpBr; bus.branch_taken_in = taken;
    step; exp_cnt++;
    step;
    total++; if ({bus.state_out, bus.br_out, bus.we_reg_out} !== {3'd3, 1'b1, 1'b0}) begin bad++;
      $display("FAIL br_exec(taken=%0b): got state=%0d br=%b we=%b want 3 1 0", taken,
               bus.state_out, bus.br_out, bus.we_reg_out); end
    total++; if (bus.pc_ctl_out !== {1'b0, taken}) begin bad++;
      $display("FAIL br_pc_ctl(taken=%0b): got %b want %b", taken, bus.pc_ctl_out, {1'b0, taken}); end
    bus.branch_taken_in = ~taken;
    #1;
    total++; if (bus.pc_ctl_out !== {1'b0, ~taken}) begin bad++;
      $display("FAIL br_pc_ctl_comb: got %b want %b", bus.pc_ctl_out, {1'b0, ~taken}); end
    bus.branch_taken_in = taken;
    step;
    total++; if ({bus.state_out, bus.pc_ctl_out, bus.br_out} !== {3'd1, 2'b00, 1'b0}) begin bad++;
      $display("FAIL br_after: got state=%0d pc_ctl=%b br=%b want 1 00 0", bus.state_out,
               bus.pc_ctl_out, bus.br_out); end
    total++; if (bus.instr_count_out !== exp_cnt) begin bad++;
      $display("FAIL br_count: got %0h want %0h", bus.instr_count_out, exp_cnt); end
  endtask

  task automatic test_jmp;
    bus.opcode_in = OpJmp;
    step; exp_cnt++;
    step;
    total++; if ({bus.pc_ctl_out, bus.br_out} !== {2'b10, 1'b0}) begin bad++;
      $display("FAIL jmp_exec: got pc_ctl=%b br=%b want 10 0", bus.pc_ctl_out, bus.br_out); end
    step;
    total++; if (bus.state_out !== 3'd1) begin bad++;
      $display("FAIL jmp_after: got %0d want 1", bus.state_out); end
  endtask

  task automatic test_ld;
    int rd_n = 0;
    bus.opcode_in = OpLd;
    step; exp_cnt++;
    step;
    bus.mem_ready_in = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus.mem_ready_in = 1'b1; #1; end
      if (bus.mem_rd_out && bus.state_out == 3'd4) rd_n++;
      step;
    end
    total++; if (rd_n != 4) begin bad++;
      $display("FAIL ld_rd_cycles: got %0d want 4", rd_n); end
    total++; if ({bus.state_out, bus.we_reg_out} !== {3'd5, 1'b1}) begin bad++;
      $display("FAIL ld_wb: got state=%0d we=%b want 5 1", bus.state_out, bus.we_reg_out); end
    step;
    total++; if (bus.state_out !== 3'd1) begin bad++;
      $display("FAIL ld_after: got %0d want 1", bus.state_out); end
  endtask

  task automatic test_st;
    int we_n = 0;
    bus.opcode_in = OpSt;
    step; exp_cnt++;
    if (bus.we_reg_out) we_n++;
    step;
    if (bus.we_reg_out) we_n++;
    step;
    total++; if ({bus.state_out, bus.mem_rd_out, bus.mem_wr_out} !== {3'd4, 2'b01}) begin bad++;
      $display("FAIL st_mem: got state=%0d rd=%b wr=%b want 4 0 1", bus.state_out,
               bus.mem_rd_out, bus.mem_wr_out); end
    if (bus.we_reg_out) we_n++;
    step;
    if (bus.we_reg_out) we_n++;
    total++; if (bus.state_out !== 3'd1 || we_n != 0) begin bad++;
      $display("FAIL st_after: got state=%0d we_pulses=%0d want 1 0", bus.state_out, we_n); end
    total++; if (bus.instr_count_out !== exp_cnt) begin bad++;
      $display("FAIL st_count: got %0h want %0h", bus.instr_count_out, exp_cnt); end
  endtask

  task automatic test_timeout;
    bus.mem_ready_in = 1'b0;
    #1;
    total++; if ({bus.mem_rd_out, bus.ir_load_out} !== 2'b10) begin bad++;
      $display("FAIL to_fetch_wait: got %b want 10", {bus.mem_rd_out, bus.ir_load_out}); end
    for (int i = 0; i < 15; i++) step;
    total++; if (bus.state_out !== 3'd1) begin bad++;
      $display("FAIL to_15cycles: got %0d want 1", bus.state_out); end
    step;
    total++; if ({bus.state_out, bus.halt_out, bus.err_out} !== {3'd6, 2'b11}) begin bad++;
      $display("FAIL to_halt: got state=%0d halt=%b err=%b want 6 1 1", bus.state_out,
               bus.halt_out, bus.err_out); end
    bus.start_in = 1'b1;
    step;
    bus.start_in = 1'b0;
    total++; if ({bus.state_out, strobes()} !== {3'd6, 6'd0}) begin bad++;
      $display("FAIL to_hold: got state=%0d strobes=%b want 6 000000", bus.state_out, strobes()); end
  endtask

  task automatic test_halt_op(input logic [3:0] op, input logic exp_err);
    do_reset;
    bus.opcode_in = op; bus.mem_ready_in = 1'b1; bus.start_in = 1'b1;
    step;
    bus.start_in = 1'b0;
    step; step; step;
    total++; if ({bus.state_out, bus.halt_out, bus.err_out} !== {3'd6, 1'b1, exp_err}) begin bad++;
      $display("FAIL halt_op_%b: got state=%0d halt=%b err=%b want 6 1 %b", op, bus.state_out,
               bus.halt_out, bus.err_out, exp_err); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.opcode_in = OpLd; bus.mem_ready_in = 1'b1; bus.start_in = 1'b1;
    step;
    bus.start_in = 1'b0;
    step; step;
    bus.mem_ready_in = 1'b0;
    step;
    total++; if ({bus.state_out, bus.mem_rd_out} !== {3'd4, 1'b1}) begin bad++;
      $display("FAIL rm_in_mem: got state=%0d rd=%b want 4 1", bus.state_out, bus.mem_rd_out); end
    #2;
    reset_in = 1'b1;
    #1;
    total++; if ({bus.state_out, strobes(), bus.instr_count_out} !== {3'd0, 6'd0, 16'd0}) begin
      bad++;
      $display("FAIL rm_async: got state=%0d strobes=%b cnt=%0h want 0 000000 0", bus.state_out,
               strobes(), bus.instr_count_out); end
    step; step;
    total++; if ({bus.state_out, strobes()} !== {3'd0, 6'd0}) begin bad++;
      $display("FAIL rm_held: got state=%0d strobes=%b want 0 000000", bus.state_out, strobes()); end
    reset_in = 1'b0;
    bus.mem_ready_in = 1'b1;
    step;
    total++; if ({bus.state_out, strobes()} !== {3'd0, 6'd0}) begin bad++;
      $display("FAIL rm_after: got state=%0d strobes=%b want 0 000000", bus.state_out, strobes()); end
  endtask

  task automatic test_wrap;
    bus.cnt_preload_in = 1'b1; bus.cnt_preload_val_in = 16'hFFFF;
    step;
    bus.cnt_preload_in = 1'b0;
    total++; if (bus.instr_count_out !== 16'hFFFF) begin bad++;
      $display("FAIL wrap_preload: got %0h want ffff", bus.instr_count_out); end
    bus.opcode_in = OpAdd; bus.mem_ready_in = 1'b1; bus.start_in = 1'b1;
    step;
    bus.start_in = 1'b0;
    step;
    total++; if (bus.instr_count_out !== 16'h0000) begin bad++;
      $display("FAIL wrap_count: got %0h want 0", bus.instr_count_out); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_branch(1'b1);
    test_branch(1'b0);
    test_jmp;
    test_ld;
    test_st;
    test_timeout;
    test_halt_op(4'b0111, 1'b1);
    test_halt_op(OpTrap, 1'b0);
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
